// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for the slice-serial ALU.
// The producer side (operand file / writeback) uses master, the ALU uses slave.
interface alu_seq_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       opcode;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             flag_c;
   logic             flag_z;
   logic             flag_n;
   logic             flag_v;

   modport master (
      output in_valid, a, b, opcode, cin, out_ready,
      input  in_ready, out_valid, result, flag_c, flag_z, flag_n, flag_v
   );

   modport slave (
      input  in_valid, a, b, opcode, cin, out_ready,
      output in_ready, out_valid, result, flag_c, flag_z, flag_n, flag_v
   );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle integer ALU: processes SLICE bits per clock LSB-first through a
// registered carry, so a WIDTH-bit operation takes WIDTH/SLICE RUN cycles.
module alu_seq #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic     clk,
   input  logic     rst_n,
   alu_seq_if.slave bus
);
   localparam int NSLICE = WIDTH / SLICE;
   localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CW-1:0]    LAST   = CW'(NSLICE - 1);
   localparam logic [WIDTH-1:0] W_MASK = WIDTH'({SLICE{1'b1}});

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_ADDC = 3'b010;
   localparam logic [2:0] OP_SUBB = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_OR   = 3'b101;
   localparam logic [2:0] OP_XOR  = 3'b110;
   localparam logic [2:0] OP_NOTA = 3'b111;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_result;
   logic [2:0]       r_op;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic             r_outValid;
   logic             r_flagC;
   logic             r_flagZ;
   logic             r_flagN;
   logic             r_flagV;

   logic             w_accept;
   logic             w_isArith;
   logic             w_carry0;
   logic             w_subIn;
   logic [31:0]      w_shift;
   logic [SLICE-1:0] w_aSlice;
   logic [SLICE-1:0] w_bSlice;
   logic [SLICE:0]   w_sum;
   logic [SLICE-1:0] w_slice;
   logic [WIDTH-1:0] w_resNext;

   assign bus.in_ready  = (r_state == S_IDLE);
   assign bus.out_valid = r_outValid;
   assign bus.result    = r_result;
   assign bus.flag_c    = r_flagC;
   assign bus.flag_z    = r_flagZ;
   assign bus.flag_n    = r_flagN;
   assign bus.flag_v    = r_flagV;

   assign w_accept  = bus.in_valid && (r_state == S_IDLE);
   assign w_isArith = ~r_op[2];
   assign w_subIn   = (bus.opcode == OP_SUB) || (bus.opcode == OP_SUBB);

   always_comb begin
      w_carry0 = 1'b0;
      case (bus.opcode)
         OP_SUB:           w_carry0 = 1'b1;
         OP_ADDC, OP_SUBB: w_carry0 = bus.cin;
         default:          w_carry0 = 1'b0;
      endcase
   end

   // One narrow adder slice, steered to bits [r_cnt*SLICE +: SLICE] by shifting.
   assign w_shift  = 32'(r_cnt) * 32'(SLICE);
   assign w_aSlice = SLICE'(r_a >> w_shift);
   assign w_bSlice = SLICE'(r_b >> w_shift);
   assign w_sum    = {1'b0, w_aSlice} + {1'b0, w_bSlice} + {{SLICE{1'b0}}, r_carry};

   always_comb begin
      w_slice = '0;
      case (r_op)
         OP_ADD, OP_SUB, OP_ADDC, OP_SUBB: w_slice = w_sum[SLICE-1:0];
         OP_AND:  w_slice = w_aSlice & w_bSlice;
         OP_OR:   w_slice = w_aSlice | w_bSlice;
         OP_XOR:  w_slice = w_aSlice ^ w_bSlice;
         OP_NOTA: w_slice = ~w_aSlice;
         default: w_slice = '0;
      endcase
   end

   assign w_resNext = (r_result & ~(W_MASK << w_shift)) | (WIDTH'(w_slice) << w_shift);

   // Flags are taken from w_resNext on the last slice so they see the full result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_a        <= '0;
         r_b        <= '0;
         r_result   <= '0;
         r_op       <= OP_ADD;
         r_carry    <= 1'b0;
         r_cnt      <= '0;
         r_outValid <= 1'b0;
         r_flagC    <= 1'b0;
         r_flagZ    <= 1'b0;
         r_flagN    <= 1'b0;
         r_flagV    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_a     <= bus.a;
                  r_b     <= w_subIn ? ~bus.b : bus.b;
                  r_op    <= bus.opcode;
                  r_carry <= w_carry0;
                  r_cnt   <= '0;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_result <= w_resNext;
               r_carry  <= w_sum[SLICE];
               if (r_cnt == LAST) begin
                  r_cnt      <= '0;
                  r_state    <= S_DONE;
                  r_outValid <= 1'b1;
                  r_flagZ    <= (w_resNext == '0);
                  r_flagN    <= w_resNext[WIDTH-1];
                  r_flagC    <= w_isArith & w_sum[SLICE];
                  r_flagV    <= w_isArith & (r_a[WIDTH-1] == r_b[WIDTH-1])
                                          & (w_resNext[WIDTH-1] != r_a[WIDTH-1]);
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  r_outValid <= 1'b0;
                  r_state    <= S_IDLE;
               end
            end
            default: begin
               r_outValid <= 1'b0;
               r_state    <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// Directed scoreboard bench for alu_seq (WIDTH=16, SLICE=4): the driver queues
// hand-computed results, a negedge monitor pops and compares on each handshake.
module tb_alu_seq;
   localparam int WIDTH  = 16;
   localparam int SLICE  = 4;
   localparam int NSLICE = WIDTH / SLICE;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_ADDC = 3'b010;
   localparam logic [2:0] OP_SUBB = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_OR   = 3'b101;
   localparam logic [2:0] OP_XOR  = 3'b110;
   localparam logic [2:0] OP_NOTA = 3'b111;

   logic clk;
   logic rst_n;

   alu_seq_if #(.WIDTH(WIDTH)) bus ();

   alu_seq #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Expected flags are packed {C, Z, N, V}.
   typedef struct {
      logic [WIDTH-1:0] res;
      logic [3:0]       flags;
      string            name;
   } expect_t;

   expect_t scoreboard[$];
   int      compareCount  = 0;
   int      mismatchCount = 0;
   int      edgeCount     = 0;
   int      acceptEdge    = 0;
   int      lastWait      = 0;
   logic    prevOutValid  = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edgeCount <= edgeCount + 1;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compareCount++;
      if (actual !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Monitor: sampled 1 time unit after the falling edge, well clear of the rising edge.
   always @(negedge clk) begin
      expect_t exp;
      #1;
      if (rst_n) begin
         if (bus.out_valid && !prevOutValid)
            checkOutput("latency", 32'(edgeCount - acceptEdge), 32'(NSLICE));
         if (bus.out_valid && bus.out_ready) begin
            if (scoreboard.size() == 0) begin
               compareCount++;
               mismatchCount++;
               $display("[TB] FAIL unexpected output: got result 0x%0h, expected no output", bus.result);
            end else begin
               exp = scoreboard.pop_front();
               checkOutput({exp.name, " result"}, 32'(bus.result), 32'(exp.res));
               checkOutput({exp.name, " flags"},
                           {28'd0, bus.flag_c, bus.flag_z, bus.flag_n, bus.flag_v},
                           {28'd0, exp.flags});
            end
         end
      end
      prevOutValid = bus.out_valid;
   end

   // Called at a falling edge; returns at the falling edge after the accepting edge.
   task automatic applyStimulus(input string name, input logic [2:0] op,
                                input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic cin, input logic [WIDTH-1:0] expRes,
                                input logic [3:0] expFlags);
      expect_t item;
      int waitCount;
      bus.a        = a;
      bus.b        = b;
      bus.opcode   = op;
      bus.cin      = cin;
      bus.in_valid = 1'b1;
      waitCount    = 0;
      while (!bus.in_ready && waitCount < 50) begin
         @(negedge clk);
         waitCount++;
      end
      lastWait = waitCount;
      if (!bus.in_ready) begin
         compareCount++;
         mismatchCount++;
         $display("[TB] FAIL %s accept: got in_ready=0 after 50 cycles, expected 1", name);
         bus.in_valid = 1'b0;
         return;
      end
      acceptEdge = edgeCount + 1;
      item.res   = expRes;
      item.flags = expFlags;
      item.name  = name;
      scoreboard.push_back(item);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic waitDrain();
      int n;
      n = 0;
      while (scoreboard.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (scoreboard.size() != 0) begin
         compareCount++;
         mismatchCount++;
         $display("[TB] FAIL drain: got %0d pending results, expected 0", scoreboard.size());
         scoreboard.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      int n;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.opcode    = OP_ADD;
      bus.cin       = 1'b0;
      bus.out_ready = 1'b1;
      repeat (2) @(negedge clk);

      checkOutput("reset in_ready",  32'(bus.in_ready), 32'd1);
      checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("reset result",    32'(bus.result), 32'd0);
      checkOutput("reset flags", {28'd0, bus.flag_c, bus.flag_z, bus.flag_n, bus.flag_v}, 32'd0);

      rst_n = 1'b1;
      @(negedge clk);

      applyStimulus("ADD ovf",     OP_ADD,  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 4'b0011);
      applyStimulus("SUB equal",   OP_SUB,  16'h0005, 16'h0005, 1'b0, 16'h0000, 4'b1100);
      applyStimulus("SUB neg",     OP_SUB,  16'h0003, 16'h0005, 1'b0, 16'hFFFE, 4'b0010);
      applyStimulus("ADDC wrap",   OP_ADDC, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 4'b1100);
      applyStimulus("SUBB cin0",   OP_SUBB, 16'h0010, 16'h0001, 1'b0, 16'h000E, 4'b1000);
      applyStimulus("XOR",         OP_XOR,  16'hA5A5, 16'hFFFF, 1'b0, 16'h5A5A, 4'b0000);
      applyStimulus("NOTA",        OP_NOTA, 16'hFFFF, 16'h1234, 1'b1, 16'h0000, 4'b0100);
      applyStimulus("AND",         OP_AND,  16'hF0F0, 16'h3C3C, 1'b0, 16'h3030, 4'b0000);
      applyStimulus("OR",          OP_OR,   16'h8001, 16'h0100, 1'b1, 16'h8101, 4'b0010);
      applyStimulus("ADD cin ign", OP_ADD,  16'h0001, 16'h0001, 1'b1, 16'h0002, 4'b0000);
      applyStimulus("ADDC ovf",    OP_ADDC, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 4'b0011);
      applyStimulus("SUBB ovf",    OP_SUBB, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 4'b1001);
      applyStimulus("ADD carry",   OP_ADD,  16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 4'b1010);
      waitDrain();

      // Backpressure: hold the result in DONE while a new bundle is offered.
      bus.out_ready = 1'b0;
      applyStimulus("bp first", OP_ADD, 16'h1000, 16'h0234, 1'b0, 16'h1234, 4'b0000);
      n = 0;
      while (!bus.out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput("bp out_valid", 32'(bus.out_valid), 32'd1);
      bus.a        = 16'h0100;
      bus.b        = 16'h0001;
      bus.opcode   = OP_SUB;
      bus.cin      = 1'b0;
      bus.in_valid = 1'b1;
      repeat (10) begin
         @(negedge clk);
         checkOutput("bp hold result", 32'(bus.result), 32'h1234);
         checkOutput("bp hold flags", {28'd0, bus.flag_c, bus.flag_z, bus.flag_n, bus.flag_v}, 32'd0);
         checkOutput("bp in_ready", 32'(bus.in_ready), 32'd0);
         checkOutput("bp hold valid", 32'(bus.out_valid), 32'd1);
      end
      bus.out_ready = 1'b1;
      applyStimulus("bp second", OP_SUB, 16'h0100, 16'h0001, 1'b0, 16'h00FF, 4'b1000);
      checkOutput("bp accept delay", 32'(lastWait), 32'd1);
      waitDrain();

      // Reset two slices into RUN: the partial result must vanish at once.
      applyStimulus("rst abort", OP_ADD, 16'h1111, 16'h2222, 1'b0, 16'h3333, 4'b0000);
      repeat (2) @(negedge clk);
      scoreboard.delete();
      rst_n = 1'b0;
      #1;
      checkOutput("rst out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("rst result",    32'(bus.result), 32'd0);
      checkOutput("rst in_ready",  32'(bus.in_ready), 32'd1);
      checkOutput("rst flags", {28'd0, bus.flag_c, bus.flag_z, bus.flag_n, bus.flag_v}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      applyStimulus("post-rst ADD", OP_ADD, 16'h1234, 16'h1111, 1'b0, 16'h2345, 4'b0000);
      waitDrain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end
endmodule
